// File: rtl/exe_stage_elastic_if.sv
// Handshake/bus bundle for the elastic Dec0 -> Int0 execute stage register.
// master = producer/consumer environment, slave = the stage itself.
interface exe_stage_elastic_if #(
    parameter int OPR_W  = 32,
    parameter int NODE_W = 16,
    parameter int GEN_W  = 12,
    parameter int DOPC_W = 10,
    parameter int INS_W  = 27,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [NODE_W-1:0] in_node;
    logic [GEN_W-1:0]  in_gen;
    logic [OPR_W-1:0]  in_opr0;
    logic [OPR_W-1:0]  in_opr1;
    logic              in_mem_wen;
    logic [DOPC_W-1:0] in_dopc;
    logic [INS_W-1:0]  in_ins;
    logic              in_pg_mul;
    logic              in_pg_sh;

    logic              flush;
    logic [GEN_W-1:0]  flush_gen;

    logic              out_valid;
    logic              out_ready;
    logic [NODE_W-1:0] out_node;
    logic [GEN_W-1:0]  out_gen;
    logic [OPR_W-1:0]  out_opr0;
    logic [OPR_W-1:0]  out_opr1;
    logic              out_mem_wen;
    logic              out_pg_mul;
    logic              out_pg_sh;
    logic [DOPC_W-4:0] out_dopc;
    logic [1:0]        out_cc;
    logic [15:0]       out_imm16;
    logic [3:0]        out_acc_sel;

    logic [CNT_W-1:0]  occupancy;
    logic [7:0]        drop_cnt;

    modport master (
        output in_valid, in_node, in_gen, in_opr0, in_opr1, in_mem_wen,
               in_dopc, in_ins, in_pg_mul, in_pg_sh, flush, flush_gen, out_ready,
        input  in_ready, out_valid, out_node, out_gen, out_opr0, out_opr1,
               out_mem_wen, out_pg_mul, out_pg_sh, out_dopc, out_cc, out_imm16,
               out_acc_sel, occupancy, drop_cnt
    );

    modport slave (
        input  in_valid, in_node, in_gen, in_opr0, in_opr1, in_mem_wen,
               in_dopc, in_ins, in_pg_mul, in_pg_sh, flush, flush_gen, out_ready,
        output in_ready, out_valid, out_node, out_gen, out_opr0, out_opr1,
               out_mem_wen, out_pg_mul, out_pg_sh, out_dopc, out_cc, out_imm16,
               out_acc_sel, occupancy, drop_cnt
    );
endinterface

// File: rtl/exe_stage_elastic.sv
// Elastic Dec/Exe stage: DEPTH-entry FIFO with generation-tagged flush and a drop counter.
// Optional EXE_STAGE_BYPASS_EN presents an input token straight to Int0 when the FIFO is empty.
module exe_stage_elastic #(
    parameter int OPR_W  = 32,
    parameter int NODE_W = 16,
    parameter int GEN_W  = 12,
    parameter int DOPC_W = 10,
    parameter int INS_W  = 27,
    parameter int DEPTH  = 2
) (
    input logic               clk,
    input logic               rst,
    exe_stage_elastic_if.slave pipe_io
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [NODE_W-1:0] node;
        logic [GEN_W-1:0]  gen;
        logic [OPR_W-1:0]  opr0;
        logic [OPR_W-1:0]  opr1;
        logic              mem_wen;
        logic [DOPC_W-1:0] dopc;
        logic [INS_W-1:0]  ins;
        logic              pg_mul;
        logic              pg_sh;
    } tok_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    tok_t             mem_q [DEPTH];
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    tok_t in_tok, head_tok, sel_tok, out_tok;
    logic fifo_empty, head_killed, fifo_vld, byp_vld, out_vld;
    logic in_match, push_hs, pop_hs, byp_take, wr_en, pop;
    logic [3:0] n_drop;

    assign in_tok = '{node: pipe_io.in_node, gen: pipe_io.in_gen, opr0: pipe_io.in_opr0,
                      opr1: pipe_io.in_opr1, mem_wen: pipe_io.in_mem_wen,
                      dopc: pipe_io.in_dopc, ins: pipe_io.in_ins,
                      pg_mul: pipe_io.in_pg_mul, pg_sh: pipe_io.in_pg_sh};

    assign fifo_empty       = (count_q == '0);
    assign pipe_io.in_ready = !rst && (count_q < CNT_W'(DEPTH));
    assign head_tok         = mem_q[rd_ptr_q];
    assign head_killed      = !fifo_empty && kill_q[rd_ptr_q];
    assign fifo_vld         = !rst && !fifo_empty && !kill_q[rd_ptr_q];

    assign in_match = pipe_io.flush && (pipe_io.in_gen == pipe_io.flush_gen);
    assign push_hs  = pipe_io.in_valid && pipe_io.in_ready;

`ifdef EXE_STAGE_BYPASS_EN
    assign byp_vld = !rst && fifo_empty && pipe_io.in_valid && !in_match;
`else
    assign byp_vld = 1'b0;
`endif

    assign out_vld  = fifo_vld || byp_vld;
    assign sel_tok  = byp_vld ? in_tok : head_tok;
    assign pop_hs   = fifo_vld && pipe_io.out_ready;
    assign byp_take = byp_vld && pipe_io.out_ready;
    assign wr_en    = push_hs && !in_match && !byp_take;
    // Killed heads drain one per cycle without ever being offered downstream.
    assign pop      = pop_hs || head_killed;

    always_comb begin
        logic [PTR_W-1:0] off;
        kill_d = kill_q;
        n_drop = {3'b0, push_hs && in_match};
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if (pipe_io.flush && ({1'b0, off} < count_q) && !kill_q[i] &&
                (mem_q[i].gen == pipe_io.flush_gen) &&
                !(pop_hs && (PTR_W'(i) == rd_ptr_q))) begin
                kill_d[i] = 1'b1;
                n_drop    = n_drop + 4'd1;
            end
        end
        if (wr_en) kill_d[wr_ptr_q] = 1'b0;
    end

    assign count_d    = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    assign rd_ptr_d   = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign drop_cnt_d = sat_add8(drop_cnt_q, n_drop);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            kill_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            kill_q     <= kill_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count/kill only.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_tok;
    end

    assign out_tok = out_vld ? sel_tok : '0;

    assign pipe_io.out_valid   = out_vld;
    assign pipe_io.out_node    = out_tok.node;
    assign pipe_io.out_gen     = out_tok.gen;
    assign pipe_io.out_opr0    = out_tok.opr0;
    assign pipe_io.out_opr1    = out_tok.opr1;
    assign pipe_io.out_mem_wen = out_tok.mem_wen;
    assign pipe_io.out_pg_mul  = out_tok.pg_mul;
    assign pipe_io.out_pg_sh   = out_tok.pg_sh;
    assign pipe_io.out_dopc    = out_tok.dopc[DOPC_W-1:3];
    assign pipe_io.out_cc      = out_tok.ins[6:5];
    assign pipe_io.out_imm16   = {11'b0, out_tok.ins[4:0]};
    assign pipe_io.out_acc_sel = out_tok.dopc[2] ? out_tok.opr1[3:0] : out_tok.ins[3:0];
    assign pipe_io.occupancy   = count_q;
    assign pipe_io.drop_cnt    = drop_cnt_q;

    logic unused_bits;
    assign unused_bits = ^{out_tok.ins[INS_W-1:7], out_tok.dopc[1:0]};
endmodule

// File: tb/tb_exe_stage_elastic.sv
// Directed bench for exe_stage_elastic: a DEPTH=2 and a DEPTH=4 instance share one stimulus.
// Bypass-dependent expectations follow EXE_STAGE_BYPASS_EN.
module tb_exe_stage_elastic;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic        in_valid  = 1'b0;
    logic [11:0] in_gen    = '0;
    logic [31:0] in_opr0   = '0;
    logic [31:0] in_opr1   = '0;
    logic [9:0]  in_dopc   = '0;
    logic [26:0] in_ins    = '0;
    logic        flush     = 1'b0;
    logic [11:0] flush_gen = '0;
    logic        out_ready = 1'b0;

    exe_stage_elastic_if #(.DEPTH(2)) if2 ();
    exe_stage_elastic_if #(.DEPTH(4)) if4 ();

    assign if2.in_valid = in_valid;   assign if4.in_valid = in_valid;
    assign if2.in_node  = {4'h0, in_gen}; assign if4.in_node = {4'h0, in_gen};
    assign if2.in_gen   = in_gen;     assign if4.in_gen   = in_gen;
    assign if2.in_opr0  = in_opr0;    assign if4.in_opr0  = in_opr0;
    assign if2.in_opr1  = in_opr1;    assign if4.in_opr1  = in_opr1;
    assign if2.in_mem_wen = 1'b0;     assign if4.in_mem_wen = 1'b0;
    assign if2.in_dopc  = in_dopc;    assign if4.in_dopc  = in_dopc;
    assign if2.in_ins   = in_ins;     assign if4.in_ins   = in_ins;
    assign if2.in_pg_mul = 1'b0;      assign if4.in_pg_mul = 1'b0;
    assign if2.in_pg_sh = 1'b0;       assign if4.in_pg_sh = 1'b0;
    assign if2.flush    = flush;      assign if4.flush    = flush;
    assign if2.flush_gen = flush_gen; assign if4.flush_gen = flush_gen;
    assign if2.out_ready = out_ready; assign if4.out_ready = out_ready;

    exe_stage_elastic #(.DEPTH(2)) u_dut2 (.clk(clk), .rst(rst), .pipe_io(if2.slave));
    exe_stage_elastic #(.DEPTH(4)) u_dut4 (.clk(clk), .rst(rst), .pipe_io(if4.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic v, input logic [11:0] g, input logic [31:0] o0);
        in_valid = v;
        in_gen   = g;
        in_opr0  = o0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;

        // In-order delivery with backpressure on the DEPTH=2 instance
        out_ready = 1'b0;
        drive(1'b1, 12'd1, 32'hA5A5A5A5);
        settle();
        chk("ord_rdy1", 64'(if2.in_ready), 64'd1);
        step();
        drive(1'b1, 12'd2, 32'h0);
        settle();
        chk("ord_rdy2", 64'(if2.in_ready), 64'd1);
        chk("ord_lat1", 64'(if2.out_valid), 64'd1);
        step();
        drive(1'b1, 12'd3, 32'hFFFFFFFF);
        settle();
        chk("ord_full_rdy", 64'(if2.in_ready), 64'd0);
        chk("ord_full_occ", 64'(if2.occupancy), 64'd2);
        chk("ord_h1_gen", 64'(if2.out_gen), 64'd1);
        chk("ord_h1_opr0", 64'(if2.out_opr0), 64'hA5A5A5A5);
        step();
        out_ready = 1'b1;
        settle();
        chk("ord_hold_gen", 64'(if2.out_gen), 64'd1);
        step();
        settle();
        chk("ord_h2_gen", 64'(if2.out_gen), 64'd2);
        chk("ord_h2_opr0", 64'(if2.out_opr0), 64'h0);
        chk("ord_h2_rdy", 64'(if2.in_ready), 64'd1);
        step();
        drive(1'b0, 12'd0, 32'h0);
        settle();
        chk("ord_h3_gen", 64'(if2.out_gen), 64'd3);
        chk("ord_h3_opr0", 64'(if2.out_opr0), 64'hFFFFFFFF);
        chk("ord_h3_occ", 64'(if2.occupancy), 64'd1);
        step();
        settle();
        chk("ord_empty_vld", 64'(if2.out_valid), 64'd0);
        chk("ord_empty_opr0", 64'(if2.out_opr0), 64'h0);
        chk("ord_empty_occ", 64'(if2.occupancy), 64'd0);

        // Reset mid-stream with two tokens held
        out_ready = 1'b0;
        drive(1'b1, 12'd8, 32'h8);
        step();
        drive(1'b1, 12'd9, 32'h9);
        step();
        drive(1'b0, 12'd0, 32'h0);
        settle();
        chk("rst_pre_occ", 64'(if2.occupancy), 64'd2);
        rst = 1'b1;
        settle();
        chk("rst_in_ready", 64'(if2.in_ready), 64'd0);
        chk("rst_out_valid", 64'(if2.out_valid), 64'd0);
        step();
        settle();
        chk("rst_occ", 64'(if2.occupancy), 64'd0);
        chk("rst_out_valid2", 64'(if2.out_valid), 64'd0);
        step();
        rst = 1'b0;
        settle();
        chk("rst_drop", 64'(if2.drop_cnt), 64'd0);
        chk("rst_occ_after", 64'(if2.occupancy), 64'd0);

        // Derived Exe fields
        in_dopc = 10'h3F8; in_ins = 27'h000007F; in_opr1 = 32'h0;
        drive(1'b1, 12'h10, 32'h10);
        step();
        in_dopc = 10'h004; in_opr1 = 32'h9;
        drive(1'b1, 12'h11, 32'h11);
        out_ready = 1'b1;
        settle();
        chk("der_cc_a", 64'(if2.out_cc), 64'd3);
        chk("der_imm_a", 64'(if2.out_imm16), 64'h001F);
        chk("der_acc_a", 64'(if2.out_acc_sel), 64'hF);
        chk("der_dopc_a", 64'(if2.out_dopc), 64'h7F);
        step();
        drive(1'b0, 12'd0, 32'h0);
        settle();
        chk("der_cc_b", 64'(if2.out_cc), 64'd3);
        chk("der_imm_b", 64'(if2.out_imm16), 64'h001F);
        chk("der_acc_b", 64'(if2.out_acc_sel), 64'h9);
        chk("der_dopc_b", 64'(if2.out_dopc), 64'h0);
        step();
        settle();
        chk("der_occ", 64'(if2.occupancy), 64'd0);
        in_dopc = '0; in_ins = '0; in_opr1 = '0;

        // Generation flush on the DEPTH=4 instance: gens 5, 7, 5 held
        out_ready = 1'b0;
        do_reset();
        drive(1'b1, 12'd5, 32'h55);
        step();
        drive(1'b1, 12'd7, 32'h77);
        step();
        drive(1'b1, 12'd5, 32'h56);
        step();
        drive(1'b0, 12'd0, 32'h0);
        settle();
        chk("fl_pre_occ", 64'(if4.occupancy), 64'd3);
        chk("fl_pre_gen", 64'(if4.out_gen), 64'd5);
        flush = 1'b1; flush_gen = 12'd5;
        step();
        flush = 1'b0;
        settle();
        chk("fl_head_vld", 64'(if4.out_valid), 64'd0);
        chk("fl_head_gen", 64'(if4.out_gen), 64'd0);
        chk("fl_occ", 64'(if4.occupancy), 64'd3);
        chk("fl_drop", 64'(if4.drop_cnt), 64'd2);
        step();
        settle();
        chk("fl_g7_vld", 64'(if4.out_valid), 64'd1);
        chk("fl_g7_gen", 64'(if4.out_gen), 64'd7);
        chk("fl_g7_occ", 64'(if4.occupancy), 64'd2);
        out_ready = 1'b1;
        step();
        settle();
        chk("fl_tail_vld", 64'(if4.out_valid), 64'd0);
        chk("fl_tail_occ", 64'(if4.occupancy), 64'd1);
        step();
        settle();
        chk("fl_drain_occ", 64'(if4.occupancy), 64'd0);
        chk("fl_drain_drop", 64'(if4.drop_cnt), 64'd2);

        // Matching flush with head popping and matching input
        out_ready = 1'b0;
        drive(1'b1, 12'd4, 32'h40);
        step();
        drive(1'b1, 12'd4, 32'h44);
        out_ready = 1'b1; flush = 1'b1; flush_gen = 12'd4;
        settle();
        chk("g4_head_vld", 64'(if4.out_valid), 64'd1);
        chk("g4_head_opr0", 64'(if4.out_opr0), 64'h40);
        step();
        flush = 1'b0;
        drive(1'b0, 12'd0, 32'h0);
        settle();
        chk("g4_occ", 64'(if4.occupancy), 64'd0);
        chk("g4_vld", 64'(if4.out_valid), 64'd0);
        chk("g4_drop", 64'(if4.drop_cnt), 64'd3);

        // Drop counter saturation
        flush = 1'b1; flush_gen = 12'h0AA;
        drive(1'b1, 12'h0AA, 32'hAA);
        for (int i = 0; i < 300; i++) step();
        flush = 1'b0;
        drive(1'b0, 12'd0, 32'h0);
        settle();
        chk("sat_drop4", 64'(if4.drop_cnt), 64'd255);
        chk("sat_drop2", 64'(if2.drop_cnt), 64'd255);
        chk("sat_occ", 64'(if4.occupancy), 64'd0);

        // Empty-FIFO latency
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 12'h33, 32'h1234);
        settle();
`ifdef EXE_STAGE_BYPASS_EN
        chk("byp_vld", 64'(if2.out_valid), 64'd1);
        chk("byp_opr0", 64'(if2.out_opr0), 64'h1234);
        chk("byp_occ", 64'(if2.occupancy), 64'd0);
        step();
        drive(1'b0, 12'd0, 32'h0);
        settle();
        chk("byp_occ_after", 64'(if2.occupancy), 64'd0);
        chk("byp_vld_after", 64'(if2.out_valid), 64'd0);
`else
        chk("lat_vld0", 64'(if2.out_valid), 64'd0);
        chk("lat_opr0_0", 64'(if2.out_opr0), 64'h0);
        step();
        drive(1'b0, 12'd0, 32'h0);
        out_ready = 1'b0;
        settle();
        chk("lat_vld1", 64'(if2.out_valid), 64'd1);
        chk("lat_opr0_1", 64'(if2.out_opr0), 64'h1234);
        chk("lat_occ", 64'(if2.occupancy), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
